// File: rtl/fir_pe_stream_io.sv
// Head/tail adapter for a FIR PE chain: frames host samples into nibble-serial
// PE traffic and gathers the last PE's nibble-serial results into 16-bit words.
module fir_pe_stream_io #(
   parameter logic [15:0] BIAS = 16'h0000,
   parameter int unsigned SKIP = 2
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        en,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        pe_rdy,
   output logic [3:0]  pe_xin,
   output logic [3:0]  pe_yin,
   input  logic        pe_vld,
   input  logic [3:0]  pe_yout,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        bubble,
   output logic [15:0] frame_cnt
);

   typedef enum logic [2:0] {P0, P1, P2, P3, P4} phase_e;

   localparam int SkipW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam logic [SkipW-1:0] SkipInit = SkipW'(SKIP);

   phase_e            phase_q, phase_d;
   logic [7:0]        sample_q, sample_d;
   logic              rdy_q;
   logic [3:0]        xin_q, xin_d;
   logic [3:0]        yin_q, yin_d;
   logic              bubble_q;
   logic [15:0]       frame_cnt_q;
   logic              startFrame;

   logic              en_q;
   logic              enRise;
   logic [2:0]        nib_q;
   logic              nibbleCyc;
   logic              lastNib;
   logic [11:0]       shift_q;
   logic [15:0]       word;
   logic [SkipW-1:0]  skip_q;
   logic [15:0]       out_data_q;
   logic              out_valid_q;

   // A frame may only begin in P0; once begun it runs to P4 regardless of en.
   assign startFrame = (phase_q == P0) && en;
   assign in_ready   = startFrame && nReset;

   always_comb begin
      phase_d  = phase_q;
      sample_d = sample_q;
      case (phase_q)
         P0: begin
            if (en) begin
               phase_d  = P1;
               sample_d = in_valid ? in_data : 8'h00;
            end
         end
         P1:      phase_d = P2;
         P2:      phase_d = P3;
         P3:      phase_d = P4;
         P4:      phase_d = P0;
         default: phase_d = P0;
      endcase
   end

   // Nibble outputs are registered from the next phase so they line up with it.
   always_comb begin
      xin_d = 4'h0;
      yin_d = 4'h0;
      case (phase_d)
         P1: begin
            xin_d = sample_d[3:0];
            yin_d = BIAS[3:0];
         end
         P2: begin
            xin_d = sample_d[7:4];
            yin_d = BIAS[7:4];
         end
         P3:      yin_d = BIAS[11:8];
         P4:      yin_d = BIAS[15:12];
         default: begin
            xin_d = 4'h0;
            yin_d = 4'h0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         phase_q     <= P0;
         sample_q    <= 8'h00;
         rdy_q       <= 1'b0;
         xin_q       <= 4'h0;
         yin_q       <= 4'h0;
         bubble_q    <= 1'b0;
         frame_cnt_q <= 16'h0000;
      end else begin
         phase_q  <= phase_d;
         sample_q <= sample_d;
         rdy_q    <= startFrame;
         xin_q    <= xin_d;
         yin_q    <= yin_d;
         if (startFrame) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (!in_valid) begin
               bubble_q <= 1'b1;
            end
         end
      end
   end

   assign enRise    = en && !en_q;
   assign nibbleCyc = (nib_q != 3'd0);
   assign lastNib   = (nib_q == 3'd4);
   assign word      = {pe_yout, shift_q};

   // nib_q counts the nibble cycle in progress (1..4); a fresh Vld always restarts at 1.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         en_q        <= 1'b0;
         nib_q       <= 3'd0;
         shift_q     <= 12'h000;
         skip_q      <= SkipInit;
         out_data_q  <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         en_q        <= en;
         out_valid_q <= 1'b0;
         if (nibbleCyc) begin
            shift_q <= {pe_yout, shift_q[11:4]};
         end
         if (pe_vld) begin
            nib_q <= 3'd1;
         end else if (lastNib) begin
            nib_q <= 3'd0;
         end else if (nibbleCyc) begin
            nib_q <= nib_q + 3'd1;
         end
         if (lastNib) begin
            if (skip_q != '0) begin
               skip_q <= skip_q - SkipW'(1);
            end else begin
               out_data_q  <= word;
               out_valid_q <= 1'b1;
            end
         end
         if (enRise) begin
            skip_q <= SkipInit;
         end
      end
   end

   assign pe_rdy    = rdy_q;
   assign pe_xin    = xin_q;
   assign pe_yin    = yin_q;
   assign bubble    = bubble_q;
   assign frame_cnt = frame_cnt_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_pe_stream_io.sv
// Bench for fir_pe_stream_io: per-cycle stimulus schedules with expected outputs
// derived from frame-start and word-completion rules.
module tb_fir_pe_stream_io;

   localparam logic [15:0] BIAS   = 16'h1234;
   localparam int          SKIP   = 2;
   localparam int          MAXLEN = 160;

   logic        clk = 1'b0;
   logic        nReset;
   logic        en;
   logic [7:0]  inData;
   logic        inValid;
   logic        inReady;
   logic        peRdy;
   logic [3:0]  peXin;
   logic [3:0]  peYin;
   logic        peVld;
   logic [3:0]  peYout;
   logic [15:0] outData;
   logic        outValid;
   logic        bubble;
   logic [15:0] frameCnt;

   int evalCount = 0;
   int failCount = 0;

   // Stimulus schedule, one entry per cycle after reset release.
   logic        sEn[MAXLEN];
   logic        sValid[MAXLEN];
   logic [7:0]  sData[MAXLEN];
   logic        sVld[MAXLEN];
   logic [3:0]  sYout[MAXLEN];
   int          wStart[$];
   logic [15:0] wVal[$];
   int          runLen;

   // Expected outputs per cycle.
   logic        eInReady[MAXLEN];
   logic        eRdy[MAXLEN];
   logic [3:0]  eXin[MAXLEN];
   logic [3:0]  eYin[MAXLEN];
   logic [15:0] eFcnt[MAXLEN];
   logic        eBubble[MAXLEN];
   logic        eOv[MAXLEN];
   logic [15:0] eOd[MAXLEN];

   fir_pe_stream_io #(.BIAS(BIAS), .SKIP(SKIP)) dut (
      .clk       (clk),
      .nReset    (nReset),
      .en        (en),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .pe_rdy    (peRdy),
      .pe_xin    (peXin),
      .pe_yin    (peYin),
      .pe_vld    (peVld),
      .pe_yout   (peYout),
      .out_data  (outData),
      .out_valid (outValid),
      .bubble    (bubble),
      .frame_cnt (frameCnt)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
      evalCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
      end
   endtask

   task automatic clearSchedule(input int len);
      runLen = len;
      wStart.delete();
      wVal.delete();
      for (int t = 0; t < MAXLEN; t++) begin
         sEn[t]    = 1'b0;
         sValid[t] = ($urandom_range(0, 7) != 0);
         sData[t]  = 8'($urandom);
         sVld[t]   = 1'b0;
         sYout[t]  = 4'($urandom);
      end
   endtask

   task automatic placeWord(input int s, input logic [15:0] v);
      sVld[s] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sYout[s + 1 + i] = v[4*i +: 4];
      end
      wStart.push_back(s);
      wVal.push_back(v);
   endtask

   // Frames start on any enabled cycle at least 5 cycles after the previous start;
   // a collected word is shown only if SKIP words already completed since the last en rise.
   task automatic buildExpected();
      int          last;
      int          cnt;
      int          d;
      logic        bub;
      logic [7:0]  samp;
      logic [15:0] od;
      logic        strobe[MAXLEN];
      logic [15:0] strobeVal[MAXLEN];
      last = -100;
      cnt  = 0;
      bub  = 1'b0;
      samp = 8'h00;
      od   = 16'h0000;
      for (int t = 0; t < MAXLEN; t++) begin
         strobe[t]    = 1'b0;
         strobeVal[t] = 16'h0000;
      end
      for (int t = 0; t < runLen; t++) begin
         d           = t - last;
         eFcnt[t]    = 16'(cnt);
         eBubble[t]  = bub;
         eRdy[t]     = (d == 1);
         eXin[t]     = (d == 1) ? samp[3:0] : (d == 2) ? samp[7:4] : 4'h0;
         eYin[t]     = (d >= 1 && d <= 4) ? 4'(BIAS >> (4 * (d - 1))) : 4'h0;
         eInReady[t] = 1'b0;
         if (sEn[t] && t >= last + 5) begin
            eInReady[t] = 1'b1;
            last = t;
            samp = sValid[t] ? sData[t] : 8'h00;
            cnt++;
            if (!sValid[t]) bub = 1'b1;
         end
      end
      for (int w = 0; w < wStart.size(); w++) begin
         int c;
         int r;
         int k;
         c = wStart[w] + 4;
         r = -1;
         k = 0;
         for (int t = 0; t <= c; t++) begin
            if (sEn[t] && (t == 0 || !sEn[t-1])) r = t;
         end
         for (int u = 0; u < wStart.size(); u++) begin
            if (wStart[u] + 4 > r && wStart[u] + 4 < c) k++;
         end
         if (k >= SKIP) begin
            strobe[c + 1]    = 1'b1;
            strobeVal[c + 1] = wVal[w];
         end
      end
      for (int t = 0; t < runLen; t++) begin
         if (strobe[t]) od = strobeVal[t];
         eOv[t] = strobe[t];
         eOd[t] = od;
      end
   endtask

   task automatic applyStimulus(input int t);
      en      = sEn[t];
      inValid = sValid[t];
      inData  = sData[t];
      peVld   = sVld[t];
      peYout  = sYout[t];
   endtask

   task automatic checkOutput(input int t);
      checkValue("in_ready",  t, 32'(inReady),  32'(eInReady[t]));
      checkValue("pe_rdy",    t, 32'(peRdy),    32'(eRdy[t]));
      checkValue("pe_xin",    t, 32'(peXin),    32'(eXin[t]));
      checkValue("pe_yin",    t, 32'(peYin),    32'(eYin[t]));
      checkValue("frame_cnt", t, 32'(frameCnt), 32'(eFcnt[t]));
      checkValue("bubble",    t, 32'(bubble),   32'(eBubble[t]));
      checkValue("out_valid", t, 32'(outValid), 32'(eOv[t]));
      checkValue("out_data",  t, 32'(outData),  32'(eOd[t]));
   endtask

   task automatic runSection();
      for (int t = 0; t < runLen; t++) begin
         @(negedge clk);
         nReset = 1'b1;
         applyStimulus(t);
         #1;
         checkOutput(t);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkValue({tag, "_in_ready"},  -1, 32'(inReady),  32'd0);
      checkValue({tag, "_pe_rdy"},    -1, 32'(peRdy),    32'd0);
      checkValue({tag, "_pe_xin"},    -1, 32'(peXin),    32'd0);
      checkValue({tag, "_pe_yin"},    -1, 32'(peYin),    32'd0);
      checkValue({tag, "_frame_cnt"}, -1, 32'(frameCnt), 32'd0);
      checkValue({tag, "_bubble"},    -1, 32'(bubble),   32'd0);
      checkValue({tag, "_out_valid"}, -1, 32'(outValid), 32'd0);
      checkValue({tag, "_out_data"},  -1, 32'(outData),  32'd0);
   endtask

   initial begin
      nReset  = 1'b0;
      en      = 1'b0;
      inValid = 1'b0;
      inData  = 8'h00;
      peVld   = 1'b0;
      peYout  = 4'h0;
      repeat (3) @(negedge clk);
      #1;
      checkResetState("reset");

      $display("[TB] continuous stream, then occasional missing samples");
      clearSchedule(102);
      for (int t = 0; t < 102; t++) begin
         sEn[t] = 1'b1;
         if (t < 50) sValid[t] = 1'b1;
      end
      sData[0]    = 8'hA7;
      sValid[60]  = 1'b0;
      sValid[100] = 1'b1;
      sData[100]  = 8'h5C;
      buildExpected();
      runSection();

      $display("[TB] reset asserted in the middle of a frame");
      @(negedge clk);
      #1;
      checkValue("pre_reset_pe_yin", 102, 32'(peYin), 32'(BIAS[7:4]));
      checkValue("pre_reset_pe_xin", 102, 32'(peXin), 32'h5);
      nReset = 1'b0;
      #1;
      checkResetState("midreset");
      repeat (2) @(negedge clk);

      $display("[TB] collector, en drop in P1 and re-enable");
      clearSchedule(100);
      for (int t = 0; t < 100; t++) begin
         sEn[t] = (t < 41) || (t >= 70);
      end
      sValid[15] = 1'b0;
      placeWord(2,  16'hABCD);
      placeWord(7,  16'hABCD);
      placeWord(12, 16'hABCD);
      placeWord(17, 16'($urandom));
      sVld[22] = 1'b1;
      placeWord(24, 16'($urandom));
      placeWord(28, 16'($urandom));
      placeWord(33, 16'($urandom));
      placeWord(38, 16'($urandom));
      placeWord(45, 16'($urandom));
      placeWord(55, 16'($urandom));
      placeWord(72, 16'($urandom));
      placeWord(77, 16'($urandom));
      placeWord(82, 16'($urandom));
      placeWord(87, 16'($urandom));
      buildExpected();
      runSection();

      $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
      $finish;
   end

endmodule

// File: doc/fir_pe_stream_io.md
Name: fir_pe_stream_io

Overview:
- Head/tail interface for a chain of FIR processing elements (PEs).
- Feeder side: accepts 8-bit samples from the host with a valid/ready handshake. Drives the first PE with a fixed 5-cycle frame: a Rdy strobe, then nibble-serial X and Y.
- Collector side: watches the last PE's Vld and captures its 4 nibble-serial Yout values into a 16-bit result. It discards pipeline-fill frames and presents results to the host.

Parameters:
- BIAS, 16'h0000, initial accumulator value injected as Yin into the first PE (nibbles LSB first).
- SKIP, 2, number of leading collected results discarded after enable rises (PE pipeline fill).

Ports:
- clk  in  1  system clock, all logic on rising edge
- nReset  in  1  asynchronous active-low reset
- en  in  1  run enable; frames are generated only while set
- in_data  in  8  host sample
- in_valid  in  1  host sample valid
- in_ready  out  1  sample accepted this cycle (in_valid & in_ready)
- pe_rdy  out  1  Rdy strobe to first PE
- pe_xin  out  4  X nibble to first PE
- pe_yin  out  4  Y nibble to first PE
- pe_vld  in  1  Vld from last PE
- pe_yout  in  4  Yout nibble from last PE
- out_data  out  16  collected result
- out_valid  out  1  one-cycle result strobe
- bubble  out  1  sticky: a frame was issued with no sample available
- frame_cnt  out  16  frames issued since reset, wraps

Behaviour:
- Reset (async, nReset=0): phase=P0, all outputs 0, and all of the following cleared:
  - internal sample register
  - collector shift register
  - skip counter (loaded to SKIP)
  - bubble
  - frame_cnt
- Feeder phase counter:
  - P0→P1→P2→P3→P4→P0, advancing every cycle while en=1.
  - When en=0, holds at P0 only after completing the current frame. A frame, once started, always finishes.
- P0 with en=1:
  - pe_rdy=1 (registered, high for exactly one cycle per frame).
  - in_ready=1 combinationally in P0 only.
  - If in_valid, in_data latches at the end of P0. Otherwise 8'h00 latches and bubble is set.
  - frame_cnt increments at the end of P0.
- pe_xin / pe_yin by phase:
  - P1: pe_xin = sample[3:0], pe_yin = BIAS[3:0]
  - P2: pe_xin = sample[7:4], pe_yin = BIAS[7:4]
  - P3: pe_xin = 0, pe_yin = BIAS[11:8]
  - P4: pe_xin = 0, pe_yin = BIAS[15:12]
  - P0: both 0
- Frame period is exactly 5 cycles with no gaps while en=1. PEs depend on back-to-back frames for Yout alignment.
- Collector:
  - A cycle with pe_vld=1 arms capture.
  - pe_yout is shifted in on each of the following 4 cycles, LSB nibble first, assembling {n3,n2,n1,n0}.
  - After the 4th nibble: if skip counter > 0, decrement it with no strobe. Otherwise register out_data and pulse out_valid for 1 cycle.
  - Latency: out_valid is asserted in the 5th cycle after the pe_vld cycle.
- pe_vld during capture:
  - If pe_vld rises again during nibbles 1–3, the current capture is abandoned and restarted.
  - pe_vld coinciding with the 4th nibble cycle completes the current word and re-arms.
- Rising edge of en reloads the skip counter to SKIP. en falling does not abort an in-flight capture.
- out_data holds its last value between strobes.
- bubble clears only on reset.

Test Plan:
- Reset mid-frame (nReset low in P2):
  - pe_rdy, pe_xin, pe_yin, out_valid, frame_cnt go 0 immediately.
  - After release with en=1, the first pe_rdy occurs in the cycle after release.
- Single sample in_data=8'hA7, BIAS=16'h1234, en=1:
  - pe_rdy pulse.
  - pe_xin sequence 7,A,0,0.
  - pe_yin sequence 4,3,2,1 in P1..P4.
  - in_ready high only in P0.
- Continuous stream with in_valid always 1:
  - pe_rdy exactly every 5 cycles.
  - frame_cnt = 10 after 50 cycles.
  - bubble stays 0.
- in_valid=0 during one P0:
  - Zero sample issued (pe_xin 0,0).
  - bubble=1 and remains set.
- Collector with SKIP=2, a pe_vld pulse every 5 cycles, and pe_yout nibbles D,C,B,A:
  - First two words produce no out_valid.
  - Third word gives out_valid with out_data=16'hABCD, 5 cycles after its pe_vld.
- en deasserted in P1:
  - Frame completes through P4 and the feeder idles at P0 with pe_rdy=0.
  - Re-enabling reloads skip, and the next SKIP words are suppressed.
